// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: data-memory responder with a posted-write store buffer.
// Ports: clk_i/rst_i (sync, active-high); dm_addr_i/dm_din_i/dm_wen_i/dm_ren_i
//   request from the core; dm_dout_o/dm_rvalid_o registered read return;
//   stall_o (comb) request not accepted; sb_empty_o buffer empty.
// Optional: DMEM_SB_STATS_EN adds fwd_hits_o and stall_cycles_o counters.
module dmem_store_buffer #(
  parameter int MEM_WORDS = 1024,
  parameter int SB_DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_din_i,
  input  logic [31:0] dm_wen_i,
  input  logic        dm_ren_i,
  output logic [31:0] dm_dout_o,
  output logic        dm_rvalid_o,
  output logic        stall_o,
  output logic        sb_empty_o
`ifdef DMEM_SB_STATS_EN
  ,
  output logic [31:0] fwd_hits_o,
  output logic [31:0] stall_cycles_o
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = $clog2(SB_DEPTH + 1);

  logic [31:0]   mem     [MEM_WORDS];
  logic [AW-1:0] sb_idx  [SB_DEPTH];
  logic [31:0]   sb_data [SB_DEPTH];
  logic [31:0]   sb_mask [SB_DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [AW-1:0] req_idx;
  logic          wr_req, full;
  logic          rd_acc, wr_acc, drain;
  logic [31:0]   fwd_word;
  logic          fwd_hit;

  // Upper address bits wrap and byte-offset bits are ignored.
  logic unused_addr;
  assign unused_addr = ^{dm_addr_i[31:AW+2], dm_addr_i[1:0]};

  assign req_idx = dm_addr_i[AW+1:2];
  assign wr_req  = |dm_wen_i;
  assign full    = (cnt == CW'(SB_DEPTH));
  assign stall_o = full & wr_req;
  assign rd_acc  = dm_ren_i & ~stall_o;
  assign wr_acc  = wr_req & ~stall_o;
  // Reads own the RAM port; a stall blocks the read, forcing a drain.
  assign drain   = (cnt != '0) & ~rd_acc;

  always_comb begin
    cnt_nxt = cnt;
    if (wr_acc && !drain) cnt_nxt = cnt + CW'(1);
    else if (!wr_acc && drain) cnt_nxt = cnt - CW'(1);
  end

  // Merge buffered stores oldest to newest over the RAM word.
  always_comb begin
    fwd_word = mem[req_idx];
    fwd_hit  = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (CW'(i) < cnt && sb_idx[head + PW'(i)] == req_idx) begin
        fwd_word = (fwd_word & ~sb_mask[head + PW'(i)])
                 | (sb_data[head + PW'(i)] & sb_mask[head + PW'(i)]);
        fwd_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && drain)
      mem[sb_idx[head]] <= (mem[sb_idx[head]] & ~sb_mask[head])
                         | (sb_data[head] & sb_mask[head]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc) begin
      sb_idx[tail]  <= req_idx;
      sb_data[tail] <= dm_din_i;
      sb_mask[tail] <= dm_wen_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head        <= '0;
      tail        <= '0;
      cnt         <= '0;
      sb_empty_o  <= 1'b1;
      dm_dout_o   <= '0;
      dm_rvalid_o <= 1'b0;
    end else begin
      if (wr_acc) tail <= tail + PW'(1);
      if (drain)  head <= head + PW'(1);
      cnt         <= cnt_nxt;
      sb_empty_o  <= (cnt_nxt == '0);
      dm_rvalid_o <= rd_acc;
      if (rd_acc) dm_dout_o <= fwd_word;
    end
  end

`ifdef DMEM_SB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fwd_hits_o     <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (rd_acc && fwd_hit && fwd_hits_o != '1)
        fwd_hits_o <= fwd_hits_o + 32'd1;
      if (stall_o && stall_cycles_o != '1)
        stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`else
  logic unused_hit;
  assign unused_hit = fwd_hit;
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed checks of forwarding, draining,
// full-buffer stall, same-cycle read/write, address wrap and reset.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, din, wen;
  logic        ren;
  logic [31:0] dout;
  logic        rvalid, stall, sb_empty;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_store_buffer #(.MEM_WORDS(1024), .SB_DEPTH(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .dm_addr_i  (addr),
    .dm_din_i   (din),
    .dm_wen_i   (wen),
    .dm_ren_i   (ren),
    .dm_dout_o  (dout),
    .dm_rvalid_o(rvalid),
    .stall_o    (stall),
    .sb_empty_o (sb_empty)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] m, input logic r);
    addr = a; din = d; wen = m; ren = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drv(32'h0, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic wait_empty(input string tag);
    drv(32'h0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 20 && !sb_empty; k++) tick();
    chk(tag, {31'b0, sb_empty}, 32'd1);
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    drv(a, 32'h0, 32'h0, 1'b1);
    tick();
    chk({tag, "_rv"}, {31'b0, rvalid}, 32'd1);
    chk(tag, dout, exp);
  endtask

  initial begin
    drv(32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Preload RAM through the port; reset does not clear RAM.
    drv(32'h10, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0); tick();
    drv(32'h30, 32'h12345678, 32'hFFFFFFFF, 1'b0); tick();
    wait_empty("preload_empty");
    rst = 1'b1;
    idle();
    rst = 1'b0;

    chk("rst_dout", dout, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_empty", {31'b0, sb_empty}, 32'd1);
    chk("rst_stall", {31'b0, stall}, 32'd0);

    rd("rd_10", 32'h10, 32'hDEADBEEF);
    chk("rd_10_empty", {31'b0, sb_empty}, 32'd1);
    idle();
    chk("rv_drop", {31'b0, rvalid}, 32'd0);
    chk("dout_hold", dout, 32'hDEADBEEF);

    // Byte write still buffered, read must forward it.
    drv(32'h10, 32'h000000AA, 32'h000000FF, 1'b0); tick();
    chk("wr_not_empty", {31'b0, sb_empty}, 32'd0);
    rd("fwd_byte", 32'h10, 32'hDEADBEAA);
    wait_empty("byte_drain");
    rd("ram_byte", 32'h10, 32'hDEADBEAA);

    // Two overlapping writes merged oldest to newest.
    drv(32'h20, 32'h11112222, 32'hFFFFFFFF, 1'b0); tick();
    drv(32'h20, 32'h0000FFFF, 32'h0000FFFF, 1'b0); tick();
    rd("fwd_merge", 32'h20, 32'h1111FFFF);
    wait_empty("merge_drain");
    rd("ram_merge", 32'h20, 32'h1111FFFF);

    // Fill buffer while reads hold the port.
    for (int i = 0; i < 4; i++) begin
      drv(32'h40 + 32'(4 * i), 32'h100 + 32'(i), 32'hFFFFFFFF, 1'b1);
      chk("fill_nostall", {31'b0, stall}, 32'd0);
      tick();
    end
    chk("fill_rd", dout, 32'h0);
    drv(32'h40, 32'hABCD0000, 32'hFFFF0000, 1'b1);
    #1;
    chk("full_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("stall_norv", {31'b0, rvalid}, 32'd0);
    chk("retry_nostall", {31'b0, stall}, 32'd0);
    tick();
    chk("retry_rv", {31'b0, rvalid}, 32'd1);
    chk("retry_prewr", dout, 32'h00000100);
    rd("after_retry", 32'h40, 32'hABCD0100);
    wait_empty("fill_drain");
    rd("ram_44", 32'h44, 32'h00000101);
    rd("ram_40", 32'h40, 32'hABCD0100);

    // Same-cycle read and write: read sees the old value.
    drv(32'h30, 32'h0, 32'hFFFFFFFF, 1'b1);
    tick();
    chk("rw_same_rv", {31'b0, rvalid}, 32'd1);
    chk("rw_same", dout, 32'h12345678);
    rd("rw_after", 32'h30, 32'h00000000);
    wait_empty("rw_drain");

    // Word index wraps modulo MEM_WORDS.
    rd("alias", 32'h1010, 32'hDEADBEAA);

    // Reset with three buffered stores discards them.
    for (int i = 0; i < 3; i++) begin
      drv(32'h10, 32'h55555555, 32'hFFFFFFFF, 1'b1);
      tick();
    end
    chk("pre_rst_full", {31'b0, sb_empty}, 32'd0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rst3_empty", {31'b0, sb_empty}, 32'd1);
    chk("rst3_dout", dout, 32'h0);
    rd("rst3_lost", 32'h10, 32'hDEADBEAA);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Data-memory responder on the far end of the core's data port: accepts the core's address, write data, per-bit write enable and read strobe, and returns read data.
- Contains a single-port word RAM and a small store buffer. Writes post immediately and drain into the RAM on cycles without a read.
- Reads forward buffered data so the core always sees program-order memory.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words; power of two.
- SB_DEPTH, 4, store-buffer entries; power of two, 2..8.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- dm_addr_i  in  32  byte address; bits [1:0] ignored; word index = addr[log2(MEM_WORDS)+1:2], upper bits ignored (wrap)
- dm_din_i  in  32  write data
- dm_wen_i  in  32  per-bit write mask; any bit set = write request
- dm_ren_i  in  1  read request
- dm_dout_o  out  32  read data, registered
- dm_rvalid_o  out  1  dm_dout_o valid this cycle
- stall_o  out  1  combinational; request not accepted, core must hold it
- sb_empty_o  out  1  store buffer empty

Behaviour:
- Reset values: dm_dout_o=0, dm_rvalid_o=0, stall_o=0, sb_empty_o=1. Buffer pointers and count cleared; buffered stores discarded; RAM contents not cleared.
- Buffer is a circular FIFO. Each entry holds {word index, data, mask}. Pointers wrap modulo SB_DEPTH. count is 0..SB_DEPTH.
- Write accepted (wen!=0 and stall_o=0): entry enqueued at tail; never written to the RAM directly.
- Drain: head entry applied to the RAM as RAM[idx] = (RAM[idx] & ~mask) | (data & mask), then dequeued. Occurs when count>0 and no accepted read this cycle.
- RAM port priority, one access per cycle: accepted read > drain.
- Full rule: count==SB_DEPTH and a write is requested → stall_o=1. That cycle is a forced drain, and any read is also not accepted. The next cycle accepts, since count has dropped.
- No other stall source; stall_o=0 when the buffer is not full.
- Read accepted (ren=1, stall_o=0):
  - dm_dout_o next cycle = RAM word merged with every valid buffer entry whose index matches, applied oldest to newest via masks.
  - dm_rvalid_o=1 for exactly that cycle. Latency is fixed at 1.
- Read and write in the same cycle, both accepted:
  - The write enqueues.
  - The read does NOT see that write, so it returns the pre-write value.
  - An entry drained in the same cycle is not possible, because the read owns the port.
- dm_dout_o holds its last value when dm_rvalid_o=0.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- sb_empty_o = (count==0), registered from next-state.
- Reset asserted mid-drain: the RAM write in that cycle does not occur.

Optional Feature:
- Macro: DMEM_SB_STATS_EN.
- Defined: adds outputs fwd_hits_o[31:0] and stall_cycles_o[31:0].
  - fwd_hits_o increments per accepted read with ≥1 matching buffer entry.
  - stall_cycles_o increments per cycle with stall_o=1.
  - Both saturate at 0xFFFFFFFF and clear on rst_i.
- Not defined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset then read addr 0x10 (RAM preloaded 0xDEADBEEF) → next cycle dm_rvalid_o=1, dm_dout_o=0xDEADBEEF, sb_empty_o=1.
- Write 0x000000AA with mask 0x000000FF to 0x10, then read 0x10 on the next cycle (entry still buffered) → 0xDEADBEAA via forwarding.
- Two writes to 0x20: 0x11112222 with mask 0xFFFFFFFF, then 0x0000FFFF with mask 0x0000FFFF; read immediately → 0x1111FFFF. After idle cycles, sb_empty_o=1 and RAM word = 0x1111FFFF.
- Fill buffer with 4 back-to-back reads-free writes while reads hold the port, then a 5th write with ren=1 → stall_o=1 that cycle, no rvalid next cycle. Request is accepted one cycle later and the read returns correct merged data.
- Same-cycle read and write to 0x30 (old 0x12345678, write 0x0 with full mask) → read returns 0x12345678; a following read returns 0x00000000.
- Address 0x1000+0x10 with MEM_WORDS=1024 → aliases word 4, returns the same data as 0x10. Assert rst_i with 3 entries buffered → sb_empty_o=1 next cycle and buffered data is lost.
